// File: rtl/dsp_frame_ctrl.sv
// dsp_frame_ctrl: frame-level sequencer for the DSP chain.
// Reads a W x H source frame in address order into the first chain stage,
// and writes whatever the last stage emits into the destination frame in order.
// It then reports completion, a chain timeout or a bad frame size.
//
// Ports:
//   dsp_clk, reset            clock, asynchronous active-high reset
//   start, abort              command pulse / level abort
//   cfg_width, cfg_height     frame dimensions, latched on an accepted start
//   feed_stall                holds off a source read this cycle
//   src_rd_en/src_addr        source memory read (data returns next cycle)
//   src_rdata                 source memory read data
//   pipe_din/pipe_dinrdy      pixel into the first DSP stage
//   pipe_dout/pipe_doutrdy    pixel from the last DSP stage (no backpressure)
//   dst_wr_en/addr/wdata      destination memory write
//   busy, done                LOAD/FEED/DRAIN indicator, completion pulse
//   err, err_code             sticky error (1 bad config, 2 timeout)
//   overrun                   sticky: chain emitted more pixels than the frame holds
module dsp_frame_ctrl #(
    parameter int unsigned PIX_W      = 24,
    parameter int unsigned DIM_W      = 12,
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned MAX_PIXELS = 1048576,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic              dsp_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic              feed_stall,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [PIX_W-1:0]  src_rdata,
    output logic [PIX_W-1:0]  pipe_din,
    output logic              pipe_dinrdy,
    input  logic [PIX_W-1:0]  pipe_dout,
    input  logic              pipe_doutrdy,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [PIX_W-1:0]  dst_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              overrun
);

    localparam int unsigned        CNT_W       = 2 * DIM_W;
    localparam int unsigned        IDLE_W      = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]   MAX_TOTAL   = CNT_W'(MAX_PIXELS);
    localparam logic [IDLE_W-1:0]  IDLE_LIMIT  = IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [IDLE_W-1:0]  IDLE_ONE    = IDLE_W'(1);
    localparam logic [1:0]         ERR_NONE    = 2'd0;
    localparam logic [1:0]         ERR_CFG     = 2'd1;
    localparam logic [1:0]         ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_nx;

    logic [DIM_W-1:0]  w_q, h_q;
    logic [CNT_W-1:0]  product, total;
    logic [CNT_W-1:0]  rd_cnt, wr_cnt, in_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    logic active;
    logic accept;
    logic cfg_bad;
    logic rd_fire;
    logic last_rd;
    logic wr_fire;
    logic last_wr;
    logic wr_drop;
    logic timeout_hit;

    assign product     = CNT_W'(w_q) * CNT_W'(h_q);
    assign cfg_bad     = (w_q == '0) || (h_q == '0) || (product > MAX_TOTAL);
    assign active      = (state == S_FEED) || (state == S_DRAIN);
    assign accept      = start && !abort && ((state == S_IDLE) || (state == S_ERR));
    assign rd_fire     = (state == S_FEED) && !feed_stall && (rd_cnt < total);
    assign last_rd     = rd_cnt == (total - CNT_ONE);
    assign wr_fire     = active && pipe_doutrdy && (wr_cnt < total);
    assign last_wr     = wr_cnt == (total - CNT_ONE);
    // A pixel arriving in the DONE cycle is still part of this frame's stream,
    // so it is counted as an overrun rather than silently lost.
    assign wr_drop     = (active || (state == S_DONE)) && pipe_doutrdy && (wr_cnt >= total);
    assign timeout_hit = active && (idle_cnt == IDLE_LIMIT);

    assign src_rd_en   = rd_fire;
    assign src_addr    = rd_fire ? rd_cnt[ADDR_W-1:0] : '0;
    // At most one read is in flight, so a read returned this cycle exactly when
    // issued reads lead accepted inputs; abort clears both counters, which
    // discards a read issued in the abort cycle.
    assign pipe_dinrdy = active && (rd_cnt != in_cnt);
    assign pipe_din    = pipe_dinrdy ? src_rdata : '0;

    always_ff @(posedge dsp_clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                busy     = 1'b1;
                state_nx = cfg_bad ? S_ERR : S_FEED;
            end
            S_FEED: begin
                busy = 1'b1;
                if (wr_fire && last_wr)      state_nx = S_DONE;
                else if (timeout_hit)        state_nx = S_ERR;
                else if (rd_fire && last_rd) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (wr_fire && last_wr) state_nx = S_DONE;
                else if (timeout_hit)   state_nx = S_ERR;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_ERR: begin
                if (start) state_nx = S_LOAD;
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    always_ff @(posedge dsp_clk or posedge reset) begin
        if (reset) begin
            w_q       <= '0;
            h_q       <= '0;
            total     <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            in_cnt    <= '0;
            idle_cnt  <= '0;
            dst_wr_en <= 1'b0;
            dst_addr  <= '0;
            dst_wdata <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            overrun   <= 1'b0;
        end else begin
            dst_wr_en <= 1'b0;
            if (abort) begin
                rd_cnt   <= '0;
                wr_cnt   <= '0;
                in_cnt   <= '0;
                idle_cnt <= '0;
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end else begin
                if (accept) begin
                    w_q      <= cfg_width;
                    h_q      <= cfg_height;
                    err      <= 1'b0;
                    err_code <= ERR_NONE;
                end
                if (state == S_LOAD) begin
                    total    <= product;
                    rd_cnt   <= '0;
                    wr_cnt   <= '0;
                    in_cnt   <= '0;
                    idle_cnt <= '0;
                    overrun  <= 1'b0;
                    if (cfg_bad) begin
                        err      <= 1'b1;
                        err_code <= ERR_CFG;
                    end
                end
                if (rd_fire)     rd_cnt <= rd_cnt + CNT_ONE;
                if (pipe_dinrdy) in_cnt <= in_cnt + CNT_ONE;
                if (wr_fire) begin
                    dst_wr_en <= 1'b1;
                    dst_addr  <= wr_cnt[ADDR_W-1:0];
                    dst_wdata <= pipe_dout;
                    wr_cnt    <= wr_cnt + CNT_ONE;
                end
                if (wr_drop) overrun <= 1'b1;
                if (active) begin
                    idle_cnt <= pipe_doutrdy ? '0 : idle_cnt + IDLE_ONE;
                end
                if (active && (state_nx == S_ERR)) begin
                    err      <= 1'b1;
                    err_code <= ERR_TIMEOUT;
                end
            end
        end
    end

endmodule
